// File: rtl/pit_wdog.sv
// Windowed-kick watchdog clocked by an upstream PIT tick: DISABLED -> RUN -> WARN -> FIRE pulse -> RUN.
// Optional macro PIT_WDOG_WINDOW_EN: a completed kick while cnt > timeout_reg>>1 counts as too early and fires.
module pit_wdog #(
    parameter int COUNT_SIZE = 16,
    parameter int DWIDTH     = 16,
    parameter int RST_PULSE  = 8
) (
    input  logic                  bus_clk,
    input  logic                  async_rst_b,
    input  logic                  sync_reset,
    input  logic                  tick_i,
    input  logic [DWIDTH-1:0]     write_data,
    input  logic                  enable_we,
    input  logic                  timeout_we,
    input  logic                  kick_we,
    output logic [COUNT_SIZE-1:0] cnt_o,
    output logic [1:0]            state_o,
    output logic                  wdog_warn_o,
    output logic                  wdog_rst_o,
    output logic                  wdog_fired_o
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_WARN     = 2'd2,
        ST_FIRE     = 2'd3
    } state_e;

    localparam logic [DWIDTH-1:0] KICK_ARM   = DWIDTH'(16'h5555);
    localparam logic [DWIDTH-1:0] KICK_DONE  = DWIDTH'(16'hAAAA);
    localparam logic [7:0]        PULSE_LAST = 8'(RST_PULSE - 1);

    state_e                  state_q, state_d;
    logic [COUNT_SIZE-1:0]   cnt_q, cnt_d;
    logic [COUNT_SIZE-1:0]   timeout_q, timeout_d;
    logic [7:0]              pulse_q, pulse_d;
    logic                    arm_q, arm_d;
    logic                    fired_q, fired_d;
    logic                    kick_done;
    logic                    fire;
    logic [COUNT_SIZE-1:0]   cnt_dec;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        pulse_d   = pulse_q;
        arm_d     = arm_q;
        fired_d   = fired_q;
        kick_done = 1'b0;
        fire      = 1'b0;
        cnt_dec   = cnt_q - COUNT_SIZE'(1);

        if (sync_reset) begin
            state_d   = ST_DISABLED;
            cnt_d     = '0;
            timeout_d = '1;
            pulse_d   = '0;
            arm_d     = 1'b0;
            fired_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_DISABLED: begin
                    if (timeout_we) timeout_d = COUNT_SIZE'(write_data);
                    if (enable_we && write_data[0]) begin
                        cnt_d   = timeout_q;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN, ST_WARN: begin
                    // Unlock needs 5555 immediately followed by AAAA; anything else disarms.
                    if (kick_we) begin
                        arm_d = (write_data == KICK_ARM);
                        kick_done = (write_data == KICK_DONE) && arm_q;
                    end
                    if (kick_done) begin
`ifdef PIT_WDOG_WINDOW_EN
                        if (cnt_q > (timeout_q >> 1)) begin
                            fire = 1'b1;
                        end else begin
                            cnt_d   = timeout_q;
                            state_d = ST_RUN;
                        end
`else
                        cnt_d   = timeout_q;
                        state_d = ST_RUN;
`endif
                    end else if (tick_i) begin
                        if (cnt_q <= COUNT_SIZE'(1)) begin
                            cnt_d = '0;
                            fire  = 1'b1;
                        end else begin
                            cnt_d = cnt_dec;
                            if (state_q == ST_RUN && cnt_dec <= (timeout_q >> 2)) state_d = ST_WARN;
                        end
                    end
                end
                ST_FIRE: begin
                    if (pulse_q == 8'd0) begin
                        cnt_d   = timeout_q;
                        state_d = ST_RUN;
                    end else begin
                        pulse_d = pulse_q - 8'd1;
                    end
                end
                default: state_d = ST_DISABLED;
            endcase

            if (fire) begin
                state_d = ST_FIRE;
                fired_d = 1'b1;
                pulse_d = PULSE_LAST;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge bus_clk or negedge async_rst_b) begin
        if (!async_rst_b) begin
            state_q   <= ST_DISABLED;
            cnt_q     <= '0;
            timeout_q <= '1;
            pulse_q   <= '0;
            arm_q     <= 1'b0;
            fired_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            pulse_q   <= pulse_d;
            arm_q     <= arm_d;
            fired_q   <= fired_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign state_o      = state_q;
    assign wdog_warn_o  = (state_q == ST_WARN);
    assign wdog_rst_o   = (state_q == ST_FIRE);
    assign wdog_fired_o = fired_q;

endmodule

// File: tb/tb_pit_wdog.sv
// Directed self-checking bench for pit_wdog (default parameters, RST_PULSE = 8).
`timescale 1ns/1ps
module tb_pit_wdog;

    logic        bus_clk = 1'b0;
    logic        async_rst_b;
    logic        sync_reset;
    logic        tick_i;
    logic [15:0] write_data;
    logic        enable_we;
    logic        timeout_we;
    logic        kick_we;
    logic [15:0] cnt_o;
    logic [1:0]  state_o;
    logic        wdog_warn_o;
    logic        wdog_rst_o;
    logic        wdog_fired_o;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] S_DIS = 2'd0, S_RUN = 2'd1, S_WARN = 2'd2, S_FIRE = 2'd3;

    pit_wdog dut (
        .bus_clk      (bus_clk),
        .async_rst_b  (async_rst_b),
        .sync_reset   (sync_reset),
        .tick_i       (tick_i),
        .write_data   (write_data),
        .enable_we    (enable_we),
        .timeout_we   (timeout_we),
        .kick_we      (kick_we),
        .cnt_o        (cnt_o),
        .state_o      (state_o),
        .wdog_warn_o  (wdog_warn_o),
        .wdog_rst_o   (wdog_rst_o),
        .wdog_fired_o (wdog_fired_o)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic apply_reset();
        async_rst_b = 1'b0;
        sync_reset  = 1'b0;
        tick_i      = 1'b0;
        write_data  = '0;
        enable_we   = 1'b0;
        timeout_we  = 1'b0;
        kick_we     = 1'b0;
        #12;
        async_rst_b = 1'b1;
        step();
    endtask

    task automatic wr_timeout(input logic [15:0] v);
        timeout_we = 1'b1; write_data = v; step(); timeout_we = 1'b0;
    endtask

    task automatic wr_enable(input logic [15:0] v);
        enable_we = 1'b1; write_data = v; step(); enable_we = 1'b0;
    endtask

    task automatic wr_kick(input logic [15:0] v);
        kick_we = 1'b1; write_data = v; step(); kick_we = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_i = 1'b1; step(); tick_i = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        chk("rst_cnt", cnt_o, 16'h0000);
        chk("rst_state", 16'(state_o), 16'(S_DIS));
        chk("rst_warn", 16'(wdog_warn_o), 16'd0);
        chk("rst_out", 16'(wdog_rst_o), 16'd0);
        chk("rst_fired", 16'(wdog_fired_o), 16'd0);
        wr_enable(16'h0000);
        chk("enable_bit0_zero_ignored", 16'(state_o), 16'(S_DIS));
        wr_enable(16'h0001);
        chk("rst_timeout_all_ones", cnt_o, 16'hFFFF);
        chk("enable_run", 16'(state_o), 16'(S_RUN));
    endtask

    task automatic test_countdown_fire();
        int pulse;
        apply_reset();
        wr_timeout(16'd8);
        wr_enable(16'h0001);
        chk("cd_load", cnt_o, 16'd8);
        ticks(5);
        chk("cd_cnt3", cnt_o, 16'd3);
        chk("cd_still_run", 16'(state_o), 16'(S_RUN));
        ticks(1);
        chk("cd_cnt2", cnt_o, 16'd2);
        chk("cd_warn_state", 16'(state_o), 16'(S_WARN));
        chk("cd_warn_out", 16'(wdog_warn_o), 16'd1);
        ticks(1);
        chk("cd_cnt1", cnt_o, 16'd1);
        chk("cd_fired_before", 16'(wdog_fired_o), 16'd0);
        ticks(1);
        chk("cd_fire_state", 16'(state_o), 16'(S_FIRE));
        chk("cd_fired", 16'(wdog_fired_o), 16'd1);
        chk("cd_warn_off", 16'(wdog_warn_o), 16'd0);
        // Tick held high through the pulse must be ignored.
        pulse = 0;
        tick_i = 1'b1;
        for (int i = 0; i < 20 && wdog_rst_o === 1'b1; i++) begin
            pulse++;
            step();
        end
        tick_i = 1'b0;
        chk("cd_pulse_len", 16'(pulse), 16'd8);
        chk("cd_after_run", 16'(state_o), 16'(S_RUN));
        chk("cd_after_cnt", cnt_o, 16'd8);
        chk("cd_fired_sticky", 16'(wdog_fired_o), 16'd1);
        sync_reset = 1'b1; tick_i = 1'b1; kick_we = 1'b1; timeout_we = 1'b1; write_data = 16'h0003;
        step();
        sync_reset = 1'b0; tick_i = 1'b0; kick_we = 1'b0; timeout_we = 1'b0;
        chk("srst_cnt", cnt_o, 16'd0);
        chk("srst_state", 16'(state_o), 16'(S_DIS));
        chk("srst_fired", 16'(wdog_fired_o), 16'd0);
        wr_enable(16'h0001);
        chk("srst_timeout_ones", cnt_o, 16'hFFFF);
    endtask

    task automatic test_kick_vs_tick();
        apply_reset();
        wr_timeout(16'd8);
        wr_enable(16'h0001);
        ticks(7);
        chk("kt_cnt1", cnt_o, 16'd1);
        wr_kick(16'h5555);
        kick_we = 1'b1; tick_i = 1'b1; write_data = 16'hAAAA;
        step();
        kick_we = 1'b0; tick_i = 1'b0;
        chk("kt_cnt", cnt_o, 16'd8);
        chk("kt_state", 16'(state_o), 16'(S_RUN));
        chk("kt_no_fire", 16'(wdog_fired_o), 16'd0);
        chk("kt_no_rst", 16'(wdog_rst_o), 16'd0);
    endtask

    task automatic test_kick_sequence();
        apply_reset();
        wr_timeout(16'd8);
        wr_enable(16'h0001);
        ticks(5);
        chk("ks_cnt3", cnt_o, 16'd3);
        wr_timeout(16'd4);
        wr_enable(16'h0001);
        chk("ks_enable_locked", 16'(state_o), 16'(S_RUN));
        wr_kick(16'hAAAA);
        chk("ks_unarmed", cnt_o, 16'd3);
        wr_kick(16'h5555); wr_kick(16'h1234); wr_kick(16'hAAAA);
        chk("ks_broken_seq", cnt_o, 16'd3);
        wr_kick(16'h5555); wr_kick(16'hAAAA);
        chk("ks_reload_old_timeout", cnt_o, 16'd8);
        ticks(1);
        wr_kick(16'h5555); wr_kick(16'h5555); wr_kick(16'hAAAA);
        chk("ks_rearm_reload", cnt_o, 16'd8);
    endtask

    task automatic test_timeout_zero();
        apply_reset();
        wr_timeout(16'd0);
        wr_enable(16'h0001);
        chk("tz_cnt", cnt_o, 16'd0);
        ticks(1);
        chk("tz_fire", 16'(state_o), 16'(S_FIRE));
        chk("tz_cnt_nowrap", cnt_o, 16'd0);
    endtask

    task automatic test_window();
        apply_reset();
        wr_timeout(16'd8);
        wr_enable(16'h0001);
        ticks(1);
        chk("win_cnt7", cnt_o, 16'd7);
        wr_kick(16'h5555); wr_kick(16'hAAAA);
`ifdef PIT_WDOG_WINDOW_EN
        chk("win_early_fire", 16'(state_o), 16'(S_FIRE));
        chk("win_early_fired", 16'(wdog_fired_o), 16'd1);
        apply_reset();
        wr_timeout(16'd8);
        wr_enable(16'h0001);
        ticks(5);
        wr_kick(16'h5555); wr_kick(16'hAAAA);
        chk("win_ok_cnt", cnt_o, 16'd8);
        chk("win_ok_fired", 16'(wdog_fired_o), 16'd0);
`else
        chk("nowin_cnt", cnt_o, 16'd8);
        chk("nowin_fired", 16'(wdog_fired_o), 16'd0);
`endif
        chk("win_state", 16'(state_o), 16'(S_RUN));
    endtask

    task automatic test_reset_mid_fire();
        apply_reset();
        wr_timeout(16'd0);
        wr_enable(16'h0001);
        ticks(1);
        step(); step(); step();
        chk("mf_in_fire", 16'(wdog_rst_o), 16'd1);
        async_rst_b = 1'b0;
        #1;
        chk("mf_async_rst", 16'(wdog_rst_o), 16'd0);
        chk("mf_async_state", 16'(state_o), 16'(S_DIS));
        chk("mf_async_fired", 16'(wdog_fired_o), 16'd0);
        async_rst_b = 1'b1;
        step();
        wr_timeout(16'd0);
        wr_enable(16'h0001);
        ticks(1);
        step(); step();
        sync_reset = 1'b1;
        #1;
        chk("mf_sync_not_immediate", 16'(wdog_rst_o), 16'd1);
        step();
        sync_reset = 1'b0;
        chk("mf_sync_rst", 16'(wdog_rst_o), 16'd0);
        chk("mf_sync_state", 16'(state_o), 16'(S_DIS));
        step();
        chk("mf_pulse_discarded", 16'(state_o), 16'(S_DIS));
    endtask

    initial begin
        test_reset();
        test_countdown_fire();
        test_kick_vs_tick();
        test_kick_sequence();
        test_timeout_zero();
        test_window();
        test_reset_mid_fire();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
